// File: rtl/bcp_driver.sv
// Initiator-side sequencer for the BCP clause checker: fetches clauses,
// drives load/evaluate pulses and applies returned implications.
module bcp_driver #(
   parameter int VAR_NUM    = 8,
   parameter int ENC_W      = 3,
   parameter int CLAUSE_NUM = 16,
   parameter int ADDR_W     = 4,
   parameter int WATCHDOG   = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [VAR_NUM-1:0] assign_in,
   input  logic [VAR_NUM-1:0] free_in,
   input  logic [ADDR_W:0]    num_clauses,
   output logic               clause_rd,
   output logic [ADDR_W-1:0]  clause_addr,
   input  logic [VAR_NUM-1:0] clause_type_in,
   input  logic [VAR_NUM-1:0] clause_mask_in,
   input  logic [VAR_NUM-1:0] clause_size_in,
   output logic               bcp_initial,
   output logic               en,
   output logic [VAR_NUM-1:0] clause_type,
   output logic [VAR_NUM-1:0] clause_mask,
   output logic [VAR_NUM-1:0] clause_size,
   output logic [VAR_NUM-1:0] assignment,
   output logic [VAR_NUM-1:0] free,
   input  logic               unit_exist,
   input  logic [ENC_W-1:0]   encoded_implication,
   input  logic               bcp_is_work,
   output logic               busy,
   output logic               done,
   output logic [VAR_NUM-1:0] impl_count,
   output logic [VAR_NUM-1:0] pass_count,
   output logic               bad_impl,
   output logic               timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_EVAL,
      S_WAIT,
      S_CHECK,
      S_NEXT,
      S_DONE
   } state_t;

   localparam int WD_W = $clog2(WATCHDOG + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG - 1);
   localparam logic [ADDR_W:0] N_MAX = (ADDR_W+1)'(CLAUSE_NUM);
   localparam logic [ADDR_W:0] N_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
   localparam logic [VAR_NUM-1:0] V_ONE = VAR_NUM'(1);

   state_t             state;
   logic [ADDR_W-1:0]  idx;
   logic [ADDR_W:0]    n_clauses;
   logic [ADDR_W:0]    last_idx;
   logic [VAR_NUM-1:0] en_cnt;
   logic [WD_W-1:0]    wd_cnt;
   logic               pass_changed;
   logic               unit_q;
   logic [ENC_W-1:0]   impl_q;
   logic [VAR_NUM-1:0] k_hot;
   logic               k_ok;

   assign last_idx = n_clauses - N_ONE;
   assign k_hot    = V_ONE << impl_q;
   // an implication is only legal on a free variable the clause covers
   assign k_ok     = (free & clause_mask & k_hot) != '0;

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= S_IDLE;
         idx          <= '0;
         n_clauses    <= '0;
         en_cnt       <= '0;
         wd_cnt       <= '0;
         pass_changed <= 1'b0;
         unit_q       <= 1'b0;
         impl_q       <= '0;
         clause_rd    <= 1'b0;
         clause_addr  <= '0;
         bcp_initial  <= 1'b0;
         en           <= 1'b0;
         clause_type  <= '0;
         clause_mask  <= '0;
         clause_size  <= '0;
         assignment   <= '0;
         free         <= '1;
         busy         <= 1'b0;
         done         <= 1'b0;
         impl_count   <= '0;
         pass_count   <= '0;
         bad_impl     <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         clause_rd   <= 1'b0;
         bcp_initial <= 1'b0;
         en          <= 1'b0;
         done        <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  assignment   <= assign_in;
                  free         <= free_in;
                  impl_count   <= '0;
                  bad_impl     <= 1'b0;
                  timeout      <= 1'b0;
                  pass_changed <= 1'b0;
                  idx          <= '0;
                  pass_count   <= V_ONE;
                  busy         <= 1'b1;
                  if (num_clauses > N_MAX)
                     n_clauses <= N_MAX;
                  else
                     n_clauses <= num_clauses;
                  if (num_clauses == '0) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     clause_rd   <= 1'b1;
                     clause_addr <= '0;
                     state       <= S_FETCH;
                  end
               end
            end
            S_FETCH: state <= S_LOAD;
            S_LOAD: begin
               clause_type <= clause_type_in;
               clause_mask <= clause_mask_in;
               clause_size <= clause_size_in;
               bcp_initial <= 1'b1;
               en_cnt      <= '0;
               if (clause_size_in == '0)
                  state <= S_NEXT;
               else
                  state <= S_EVAL;
            end
            S_EVAL: begin
               en     <= 1'b1;
               en_cnt <= en_cnt + V_ONE;
               wd_cnt <= '0;
               state  <= S_WAIT;
            end
            S_WAIT: begin
               if (!bcp_is_work) begin
                  if (en_cnt < clause_size) begin
                     state <= S_EVAL;
                  end else begin
                     unit_q <= unit_exist;
                     impl_q <= encoded_implication;
                     state  <= S_CHECK;
                  end
               end else if (wd_cnt == WD_LAST) begin
                  timeout <= 1'b1;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            S_CHECK: begin
               if (unit_q && k_ok) begin
                  assignment   <= (assignment & ~k_hot)
                                | (clause_type & k_hot);
                  free         <= free & ~k_hot;
                  pass_changed <= 1'b1;
                  if (impl_count != '1)
                     impl_count <= impl_count + V_ONE;
               end else if (unit_q) begin
                  bad_impl <= 1'b1;
               end
               state <= S_NEXT;
            end
            S_NEXT: begin
               if ({1'b0, idx} == last_idx) begin
                  if (pass_changed && free != '0) begin
                     idx          <= '0;
                     pass_changed <= 1'b0;
                     clause_rd    <= 1'b1;
                     clause_addr  <= '0;
                     state        <= S_FETCH;
                     if (pass_count != '1)
                        pass_count <= pass_count + V_ONE;
                  end else begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               end else begin
                  idx         <= idx + A_ONE;
                  clause_rd   <= 1'b1;
                  clause_addr <= idx + A_ONE;
                  state       <= S_FETCH;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
